if_id_fifo: RTL

Decoupling queue between the instruction fetch stage and the decode stage. Captures each fetched {pc, instruction} pair under a valid/ready handshake and presents them in order to decode. Lets fetch run ahead while decode stalls, and discards in-flight fetches when a branch is taken. Its `in_ready` drives the fetch stage's freeze input: freeze = !in_ready.

---
 rtl/if_id_pkg.sv | 13 +
 rtl/if_id_fifo_mem.sv | 28 ++
 rtl/if_id_fifo.sv | 122 ++++++++++++
 3 files changed

// File: rtl/if_id_pkg.sv
// Shared types and constants for the IF/ID decoupling queue.
package if_id_pkg;

  localparam int unsigned IF_ID_FIFO_DEPTH_DEFAULT = 4;
  localparam int unsigned XLEN                     = 32;

  // One queued fetch result.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instruction;
  } if_id_entry_t;

endpackage : if_id_pkg

// File: rtl/if_id_fifo_mem.sv
// Register-array storage for the IF/ID queue: one write port, asynchronous read.
// Contents are deliberately not reset; occupancy is tracked by the pointers.
module if_id_fifo_mem
  import if_id_pkg::*;
#(
  parameter int unsigned DEPTH = IF_ID_FIFO_DEPTH_DEFAULT,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  if_id_entry_t  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output if_id_entry_t  rdata_o
);

  if_id_entry_t mem_q [DEPTH];

  // Write the addressed entry on an accepted store.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : if_id_fifo_mem

// File: rtl/if_id_fifo.sv
// IF/ID decoupling queue: in-order {pc, instruction} FIFO between fetch and decode
// with flush on taken branch. in_ready feeds fetch's freeze (freeze = !in_ready).
// Optional feature: define IF_ID_FIFO_BYPASS_EN for zero-latency pass-through
// on an empty queue; otherwise outputs depend only on registered state.
module if_id_fifo
  import if_id_pkg::*;
#(
  parameter int unsigned DEPTH = IF_ID_FIFO_DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [XLEN-1:0]          in_instruction,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_instruction,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] count_q, count_d;

  logic          empty_c;
  logic          full_c;
  logic          pass_c;
  logic          push_c;
  logic          store_c;
  logic          mem_pop_c;
  logic          mem_we_c;
  if_id_entry_t  wr_entry_c;
  if_id_entry_t  rd_entry_c;

  // Occupancy status straight from the registered pointers.
  assign empty_c = (wr_ptr_q == rd_ptr_q);
  assign full_c  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[AW] != rd_ptr_q[AW]);

`ifdef IF_ID_FIFO_BYPASS_EN
  // Empty queue forwards the incoming pair combinationally.
  assign pass_c = empty_c && !flush && !rst && in_valid;
`else
  assign pass_c = 1'b0;
`endif

  // A full queue refuses pushes regardless of out_ready, keeping decode off fetch's path.
  assign in_ready  = !full_c;
  assign out_valid = !empty_c || pass_c;
  assign push_c    = in_valid && !full_c;
  // A passed-through pair that decode takes immediately is never stored.
  assign store_c   = push_c && !(pass_c && out_ready);
  assign mem_pop_c = !empty_c && out_ready;
  assign mem_we_c  = store_c && !rst && !flush;

  assign wr_entry_c = '{pc: in_pc, instruction: in_instruction};

  // Head presentation: stored head, bypassed input, or zeros when empty.
  always_comb begin
    out_pc          = '0;
    out_instruction = '0;
    if (!empty_c) begin
      out_pc          = rd_entry_c.pc;
      out_instruction = rd_entry_c.instruction;
    end else if (pass_c) begin
      out_pc          = in_pc;
      out_instruction = in_instruction;
    end
  end

  // Pointer and occupancy next state; reset and flush both empty the queue.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (rst || flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (store_c) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (mem_pop_c) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({store_c, mem_pop_c})
        2'b10:   count_d = count_q + PW'(1);
        2'b01:   count_d = count_q - PW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    wr_ptr_q <= wr_ptr_d;
    rd_ptr_q <= rd_ptr_d;
    count_q  <= count_d;
  end

  assign count = count_q;

  if_id_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we_c),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (wr_entry_c),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (rd_entry_c)
  );

endmodule : if_id_fifo
